// File: rtl/commit_pkg.sv
// Shared types and helpers for the commit reorder stage.
//   rob_entry_t  : payload held in one reorder slot {result, dest, dest_acc, commits}
//   off_class_e  : classification of a tag relative to the ROB head
//   saturate()   : signed clamp of a 2*W result into the W-bit channel range
// The entry layout is sized from the channel configuration below; the top-level
// DATA_W / N_CHANNELS parameters default to these values and must agree with them.
package commit_pkg;

    localparam int unsigned COMMIT_DATA_W     = 16;
    localparam int unsigned COMMIT_N_CHANNELS = 16;
    localparam int unsigned COMMIT_CH_ADDR_W  = $clog2(COMMIT_N_CHANNELS);

    typedef struct packed {
        logic [2*COMMIT_DATA_W-1:0]  result;
        logic [COMMIT_CH_ADDR_W-1:0] dest;
        logic                        dest_acc;
        logic                        commits;
    } rob_entry_t;

    typedef enum logic [1:0] {
        OffWin,
        OffStale,
        OffAhead
    } off_class_e;

    // In range exactly when the upper half plus the narrow sign bit are all equal.
    function automatic logic [COMMIT_DATA_W-1:0] saturate(
        input logic [2*COMMIT_DATA_W-1:0] v
    );
        logic [COMMIT_DATA_W:0] top;
        top = v[2*COMMIT_DATA_W-1:COMMIT_DATA_W-1];
        if ((&top) || !(|top)) begin
            return v[COMMIT_DATA_W-1:0];
        end else if (v[2*COMMIT_DATA_W-1]) begin
            return {1'b1, {(COMMIT_DATA_W-1){1'b0}}};
        end else begin
            return {1'b0, {(COMMIT_DATA_W-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/commit_reorder_master_if.sv
// Branch-to-commit handshake bundle.
//   in_valid / in_ready : per-branch valid and combinational accept
//   result, dest, dest_acc, commits, commit_id : per-branch tagged payload
// master: producing branches; slave: the commit stage.
interface commit_reorder_master_if #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned N_BRANCHES = 4,
    parameter int unsigned CH_ADDR_W  = 4,
    parameter int unsigned ID_W       = 9
);

    logic [N_BRANCHES-1:0]                 in_valid;
    logic [N_BRANCHES-1:0][2*DATA_W-1:0]   result;
    logic [N_BRANCHES-1:0][CH_ADDR_W-1:0]  dest;
    logic [N_BRANCHES-1:0]                 dest_acc;
    logic [N_BRANCHES-1:0]                 commits;
    logic [N_BRANCHES-1:0][ID_W-1:0]       commit_id;
    logic [N_BRANCHES-1:0]                 in_ready;

    modport master (
        output in_valid, result, dest, dest_acc, commits, commit_id,
        input  in_ready
    );

    modport slave (
        input  in_valid, result, dest, dest_acc, commits, commit_id,
        output in_ready
    );

endinterface

// File: rtl/commit_rob.sv
// Reorder slot array.
//   slot_wr / slot_wr_data : per-slot write strobes and payloads (distinct slots)
//   head_idx / head_clr    : head slot selector and retire clear
//   slot_full              : per-slot occupancy
//   head_entry             : payload of the head slot
//   count                  : number of occupied slots
module commit_rob
    import commit_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = 8,
    localparam int unsigned IDX_W    = $clog2(ROB_DEPTH),
    localparam int unsigned CNT_W    = IDX_W + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ROB_DEPTH-1:0]        slot_wr,
    input  rob_entry_t [ROB_DEPTH-1:0]  slot_wr_data,
    input  logic [IDX_W-1:0]            head_idx,
    input  logic                        head_clr,
    output logic [ROB_DEPTH-1:0]        slot_full,
    output rob_entry_t                  head_entry,
    output logic [CNT_W-1:0]            count
);

    rob_entry_t [ROB_DEPTH-1:0] slot_q;
    logic [ROB_DEPTH-1:0]       full_q, full_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [CNT_W-1:0]           n_wr;

    // The top never writes a full slot, so a write and the head clear never collide.
    always_comb begin
        full_d = full_q;
        n_wr   = '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            if (slot_wr[i]) begin
                full_d[i] = 1'b1;
                n_wr      = n_wr + CNT_W'(1);
            end
        end
        if (head_clr) begin
            full_d[head_idx] = 1'b0;
        end
        count_d = count_q + n_wr - CNT_W'(head_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q  <= '0;
            full_q  <= '0;
            count_q <= '0;
        end else begin
            full_q  <= full_d;
            count_q <= count_d;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                if (slot_wr[i]) begin
                    slot_q[i] <= slot_wr_data[i];
                end
            end
        end
    end

    assign slot_full  = full_q;
    assign head_entry = slot_q[head_idx];
    assign count      = count_q;

endmodule

// File: rtl/commit_reorder_master.sv
// Out-of-order commit stage: accepts tagged results from N branches, buffers them in a
// reorder buffer indexed by commit ID and retires them in ID order.
//   clk, reset          : clock, asynchronous active-high reset
//   enable              : global run enable
//   sample_tick/_in     : new input sample, written to channel 0 (has priority over retire)
//   br                  : branch handshake bundle (slave side)
//   channel_write_*     : channel register file write port (one-cycle enable)
//   acc_write_*         : accumulator write port (one-cycle enable)
//   next_commit_id      : ID of the ROB head
//   rob_count           : occupied slots
//   err_stale           : sticky, a tag older than the head was presented
module commit_reorder_master
    import commit_pkg::*;
#(
    parameter int unsigned DATA_W     = COMMIT_DATA_W,
    parameter int unsigned N_BRANCHES = 4,
    parameter int unsigned N_CHANNELS = COMMIT_N_CHANNELS,
    parameter int unsigned ID_W       = 9,
    parameter int unsigned ROB_DEPTH  = 8,
    parameter int unsigned SAT_MODE   = 0,
    localparam int unsigned CH_ADDR_W = $clog2(N_CHANNELS),
    localparam int unsigned CNT_W     = $clog2(ROB_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    sample_tick,
    input  logic [DATA_W-1:0]       sample_in,
    commit_reorder_master_if.slave  br,
    output logic [CH_ADDR_W-1:0]    channel_write_addr,
    output logic [DATA_W-1:0]       channel_write_val,
    output logic                    channel_write_enable,
    output logic [2*DATA_W-1:0]     acc_write_val,
    output logic                    acc_write_enable,
    output logic [ID_W-1:0]         next_commit_id,
    output logic [CNT_W-1:0]        rob_count,
    output logic                    err_stale
);

    localparam int unsigned IDX_W = $clog2(ROB_DEPTH);

    logic [ID_W-1:0]      next_id_q, next_id_d;
    logic                 err_stale_q, err_stale_d;
    logic [CH_ADDR_W-1:0] ch_addr_q, ch_addr_d;
    logic [DATA_W-1:0]    ch_val_q, ch_val_d;
    logic                 ch_en_q, ch_en_d;
    logic [2*DATA_W-1:0]  acc_val_q, acc_val_d;
    logic                 acc_en_q, acc_en_d;

    logic [ROB_DEPTH-1:0]       slot_wr, slot_full;
    rob_entry_t [ROB_DEPTH-1:0] slot_wr_data;
    rob_entry_t                 head_entry;
    logic [IDX_W-1:0]           head_idx;
    logic                       head_is_ch, retire, stale_seen;
    logic [DATA_W-1:0]          narrowed;
    logic [N_BRANCHES-1:0]      ready;

    logic [ID_W-1:0]  offset    [N_BRANCHES];
    logic [IDX_W-1:0] slot_of   [N_BRANCHES];
    off_class_e       off_class [N_BRANCHES];

    // Tag classification relative to the head; wraps naturally in ID_W bits.
    always_comb begin
        for (int i = 0; i < N_BRANCHES; i++) begin
            offset[i]  = br.commit_id[i] - next_id_q;
            slot_of[i] = br.commit_id[i][IDX_W-1:0];
            if (offset[i] < ID_W'(ROB_DEPTH)) begin
                off_class[i] = OffWin;
            end else if (offset[i][ID_W-1]) begin
                off_class[i] = OffStale;
            end else begin
                off_class[i] = OffAhead;
            end
        end
    end

    // Arbitration: slot_wr doubles as the "claimed by a lower branch" mask, since a
    // lower branch targeting an empty slot in the window is always accepted.
    always_comb begin
        slot_wr      = '0;
        slot_wr_data = '0;
        ready        = '0;
        stale_seen   = 1'b0;
        for (int i = 0; i < N_BRANCHES; i++) begin
            if (enable) begin
                case (off_class[i])
                    OffWin:   ready[i] = !slot_full[slot_of[i]] && !slot_wr[slot_of[i]];
                    OffStale: ready[i] = 1'b1;
                    default:  ready[i] = 1'b0;
                endcase
            end
            if (br.in_valid[i] && ready[i]) begin
                if (off_class[i] == OffWin) begin
                    slot_wr[slot_of[i]]               = 1'b1;
                    slot_wr_data[slot_of[i]].result   = br.result[i];
                    slot_wr_data[slot_of[i]].dest     = br.dest[i];
                    slot_wr_data[slot_of[i]].dest_acc = br.dest_acc[i];
                    slot_wr_data[slot_of[i]].commits  = br.commits[i];
                end else begin
                    stale_seen = 1'b1;
                end
            end
        end
    end

    assign br.in_ready = ready;

    commit_rob #(
        .ROB_DEPTH (ROB_DEPTH)
    ) u_rob (
        .clk          (clk),
        .reset        (reset),
        .slot_wr      (slot_wr),
        .slot_wr_data (slot_wr_data),
        .head_idx     (head_idx),
        .head_clr     (retire),
        .slot_full    (slot_full),
        .head_entry   (head_entry),
        .count        (rob_count)
    );

    assign head_idx   = next_id_q[IDX_W-1:0];
    assign head_is_ch = head_entry.commits && !head_entry.dest_acc;
    // The sample write owns the channel port, so only a channel-bound head must wait.
    assign retire     = enable && slot_full[head_idx] && !(sample_tick && head_is_ch);
    assign narrowed   = (SAT_MODE != 0) ? saturate(head_entry.result)
                                        : head_entry.result[DATA_W-1:0];

    always_comb begin
        next_id_d   = next_id_q;
        err_stale_d = err_stale_q | stale_seen;
        ch_addr_d   = ch_addr_q;
        ch_val_d    = ch_val_q;
        ch_en_d     = 1'b0;
        acc_val_d   = acc_val_q;
        acc_en_d    = 1'b0;
        if (retire) begin
            next_id_d = next_id_q + ID_W'(1);
            if (head_entry.commits) begin
                if (head_entry.dest_acc) begin
                    acc_val_d = head_entry.result;
                    acc_en_d  = 1'b1;
                end else begin
                    ch_addr_d = head_entry.dest;
                    ch_val_d  = narrowed;
                    ch_en_d   = 1'b1;
                end
            end
        end
        if (enable && sample_tick) begin
            ch_addr_d = '0;
            ch_val_d  = sample_in;
            ch_en_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_id_q   <= '0;
            err_stale_q <= 1'b0;
            ch_addr_q   <= '0;
            ch_val_q    <= '0;
            ch_en_q     <= 1'b0;
            acc_val_q   <= '0;
            acc_en_q    <= 1'b0;
        end else begin
            next_id_q   <= next_id_d;
            err_stale_q <= err_stale_d;
            ch_addr_q   <= ch_addr_d;
            ch_val_q    <= ch_val_d;
            ch_en_q     <= ch_en_d;
            acc_val_q   <= acc_val_d;
            acc_en_q    <= acc_en_d;
        end
    end

    assign channel_write_addr   = ch_addr_q;
    assign channel_write_val    = ch_val_q;
    assign channel_write_enable = ch_en_q;
    assign acc_write_val        = acc_val_q;
    assign acc_write_enable     = acc_en_q;
    assign next_commit_id       = next_id_q;
    assign err_stale            = err_stale_q;

endmodule

// File: tb/tb_commit_reorder_master.sv
// Directed bench for commit_reorder_master. Two instances see identical stimulus:
// dut (truncating) and dut_s (saturating). Expected writes are queued when stimulus is
// issued; a negedge monitor pops and compares every write pulse of either instance.
module tb_commit_reorder_master;

    logic        clk = 1'b0;
    logic        reset, enable, sample_tick;
    logic [15:0] sample_in;

    always #5 clk = ~clk;

    commit_reorder_master_if #(.DATA_W(16), .N_BRANCHES(4), .CH_ADDR_W(4), .ID_W(9)) bus ();
    commit_reorder_master_if #(.DATA_W(16), .N_BRANCHES(4), .CH_ADDR_W(4), .ID_W(9)) bus_s ();

    assign bus_s.in_valid  = bus.in_valid;
    assign bus_s.result    = bus.result;
    assign bus_s.dest      = bus.dest;
    assign bus_s.dest_acc  = bus.dest_acc;
    assign bus_s.commits   = bus.commits;
    assign bus_s.commit_id = bus.commit_id;

    logic [3:0]  ch_addr_m, ch_addr_s;
    logic [15:0] ch_val_m, ch_val_s;
    logic        ch_en_m, ch_en_s, acc_en_m, acc_en_s;
    logic [31:0] acc_val_m, acc_val_s;
    logic [8:0]  next_m, next_s;
    logic [3:0]  cnt_m, cnt_s;
    logic        err_m, err_s;

    commit_reorder_master #(
        .DATA_W(16), .N_BRANCHES(4), .N_CHANNELS(16), .ID_W(9), .ROB_DEPTH(8), .SAT_MODE(0)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_tick(sample_tick),
        .sample_in(sample_in), .br(bus.slave),
        .channel_write_addr(ch_addr_m), .channel_write_val(ch_val_m),
        .channel_write_enable(ch_en_m), .acc_write_val(acc_val_m),
        .acc_write_enable(acc_en_m), .next_commit_id(next_m), .rob_count(cnt_m),
        .err_stale(err_m)
    );

    commit_reorder_master #(
        .DATA_W(16), .N_BRANCHES(4), .N_CHANNELS(16), .ID_W(9), .ROB_DEPTH(8), .SAT_MODE(1)
    ) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .sample_tick(sample_tick),
        .sample_in(sample_in), .br(bus_s.slave),
        .channel_write_addr(ch_addr_s), .channel_write_val(ch_val_s),
        .channel_write_enable(ch_en_s), .acc_write_val(acc_val_s),
        .acc_write_enable(acc_en_s), .next_commit_id(next_s), .rob_count(cnt_s),
        .err_stale(err_s)
    );

    typedef struct {
        bit          kind;   // 0 channel, 1 accumulator
        logic [3:0]  addr;
        logic [31:0] val;
    } exp_t;

    exp_t ch_q[$];
    exp_t sat_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic push_ch(input logic [3:0] a, input logic [15:0] v_trunc,
                           input logic [15:0] v_sat);
        ch_q.push_back('{1'b0, a, {16'h0000, v_trunc}});
        sat_q.push_back('{1'b0, a, {16'h0000, v_sat}});
    endtask

    task automatic push_acc(input logic [31:0] v);
        ch_q.push_back('{1'b1, 4'h0, v});
        sat_q.push_back('{1'b1, 4'h0, v});
    endtask

    task automatic mon(input int which, input bit kind, input logic [3:0] addr,
                       input logic [31:0] val);
        exp_t e;
        total++;
        if ((which == 0 && ch_q.size() == 0) || (which == 1 && sat_q.size() == 0)) begin
            bad++;
            $display("FAIL unexpected_write dut=%0d kind=%0d got addr=%0d val=%h want none",
                     which, kind, addr, val);
            return;
        end
        e = (which == 0) ? ch_q.pop_front() : sat_q.pop_front();
        if (e.kind !== kind || e.addr !== addr || e.val !== val) begin
            bad++;
            $display("FAIL write dut=%0d got kind=%0d addr=%0d val=%h want kind=%0d addr=%0d val=%h",
                     which, kind, addr, val, e.kind, e.addr, e.val);
        end
    endtask

    always @(negedge clk) begin
        if (ch_en_m)  mon(0, 1'b0, ch_addr_m, {16'h0000, ch_val_m});
        if (acc_en_m) mon(0, 1'b1, 4'h0, acc_val_m);
        if (ch_en_s)  mon(1, 1'b0, ch_addr_s, {16'h0000, ch_val_s});
        if (acc_en_s) mon(1, 1'b1, 4'h0, acc_val_s);
    end

    // Phase convention: stimulus tasks start and end 1 time unit after a posedge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int b, input int id, input logic [3:0] d,
                         input logic [31:0] res, input bit acc, input bit cm);
        logic [31:0] idv;
        idv = id;
        bus.commit_id[b] = idv[8:0];
        bus.dest[b]      = d;
        bus.result[b]    = res;
        bus.dest_acc[b]  = acc;
        bus.commits[b]   = cm;
        bus.in_valid[b]  = 1'b1;
    endtask

    task automatic wait_accept(input int b);
        logic rdy;
        int   n;
        n = 0;
        while (1) begin
            #1;
            rdy = bus.in_ready[b];
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 64) begin
                total++;
                bad++;
                $display("FAIL accept_timeout branch=%0d got in_ready=0 want 1", b);
                break;
            end
        end
        bus.in_valid[b] = 1'b0;
    endtask

    task automatic send(input int b, input int id, input logic [3:0] d,
                        input logic [31:0] res, input bit acc, input bit cm);
        drive(b, id, d, res, acc, cm);
        wait_accept(b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; enable = 1'b1; sample_tick = 1'b0; sample_in = '0;
        bus.in_valid = '0; bus.result = '0; bus.dest = '0;
        bus.dest_acc = '0; bus.commits = '0; bus.commit_id = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_next", next_m, 0);
        check("rst_count", cnt_m, 0);
        check("rst_err", err_m, 0);
        check("rst_outs", {ch_en_m, acc_en_m, ch_addr_m, ch_val_m}, 0);
        check("rst_acc_val", acc_val_m, 0);

        // enable=0 blocks acceptance and holds state
        push_ch(4'd3, 16'h1234, 16'h1234);
        enable = 1'b0;
        drive(0, 0, 4'd3, 32'h0000_1234, 1'b0, 1'b1);
        #1;
        check("dis_ready", bus.in_ready[0], 0);
        tick(2);
        check("dis_count", cnt_m, 0);
        enable = 1'b1;
        wait_accept(0);

        // In order, with first-transfer latency
        check("lat_early", ch_en_m, 0);
        tick(1);
        check("lat_t2", {ch_en_m, ch_addr_m}, {1'b1, 4'd3});
        push_ch(4'd4, 16'h1235, 16'h1235);
        push_ch(4'd5, 16'h1236, 16'h1236);
        send(0, 1, 4'd4, 32'h0000_1235, 1'b0, 1'b1);
        send(0, 2, 4'd5, 32'h0000_1236, 1'b0, 1'b1);
        tick(3);
        check("inorder_next", next_m, 3);
        check("inorder_count", cnt_m, 0);

        // Out of order: ID4 (acc) arrives before ID3 (channel)
        push_ch(4'd2, 16'h0005, 16'h0005);
        push_acc(32'h0000_0007);
        send(1, 4, 4'd0, 32'h0000_0007, 1'b1, 1'b1);
        check("ooo_count", cnt_m, 1);
        check("ooo_hold_next", next_m, 3);
        send(0, 3, 4'd2, 32'h0000_0005, 1'b0, 1'b1);
        tick(4);
        check("ooo_next", next_m, 5);

        // Sample tick vs channel-bound head: head waits one cycle
        push_ch(4'd0, 16'h8001, 16'h8001);
        push_ch(4'd6, 16'h00AB, 16'h00AB);
        send(0, 5, 4'd6, 32'h0000_00AB, 1'b0, 1'b1);
        sample_tick = 1'b1; sample_in = 16'h8001;
        tick(1);
        sample_tick = 1'b0;
        tick(3);
        check("tick_ch_next", next_m, 6);

        // Sample tick vs accumulator-bound head: both in the same cycle
        push_ch(4'd0, 16'h0042, 16'h0042);
        push_acc(32'h0001_0002);
        send(0, 6, 4'd0, 32'h0001_0002, 1'b1, 1'b1);
        sample_tick = 1'b1; sample_in = 16'h0042;
        tick(1);
        check("tick_acc_same", {ch_en_m, acc_en_m}, 2'b11);
        sample_tick = 1'b0;
        tick(3);
        check("tick_acc_next", next_m, 7);

        // Narrowing: truncating vs saturating instance
        push_ch(4'd1, 16'h0000, 16'h7FFF);
        send(0, 7, 4'd1, 32'h0001_0000, 1'b0, 1'b1);
        push_ch(4'd1, 16'h0000, 16'h8000);
        send(0, 8, 4'd1, 32'hFFFE_0000, 1'b0, 1'b1);
        push_ch(4'd1, 16'hFFFE, 16'hFFFE);
        send(0, 9, 4'd1, 32'hFFFF_FFFE, 1'b0, 1'b1);
        tick(3);
        check("sat_next", next_m, 10);

        // Backpressure: ID18 is one past the window while the head is 10
        push_ch(4'd7, 16'h000A, 16'h000A);
        for (int id = 11; id <= 17; id++) begin
            logic [31:0] idv;
            idv = id;
            push_ch(idv[3:0], idv[15:0], idv[15:0]);
        end
        push_ch(4'd8, 16'h0012, 16'h0012);
        drive(1, 18, 4'd8, 32'h0000_0012, 1'b0, 1'b1);
        #1;
        check("ahead_ready", bus.in_ready[1], 0);
        send(0, 10, 4'd7, 32'h0000_000A, 1'b0, 1'b1);
        #1;
        check("ahead_hold", bus.in_ready[1], 0);
        wait_accept(1);
        for (int id = 11; id <= 17; id++) begin
            logic [31:0] idv;
            idv = id;
            send(0, id, idv[3:0], idv, 1'b0, 1'b1);
        end
        tick(4);
        check("bp_next", next_m, 19);
        check("bp_count", cnt_m, 0);

        // Stale: already-retired ID10 is accepted and dropped
        check("stale_pre", err_m, 0);
        drive(2, 10, 4'd0, 32'h0000_0099, 1'b0, 1'b1);
        #1;
        check("stale_ready", bus.in_ready[2], 1);
        wait_accept(2);
        tick(2);
        check("stale_err", err_m, 1);
        check("stale_count", cnt_m, 0);
        check("stale_next", next_m, 19);

        // Walk the head to 510 with non-writing entries
        for (int id = 19; id < 510; id++) begin
            send(0, id, 4'd0, 32'h0, 1'b0, 1'b0);
        end
        tick(3);
        check("prewrap_next", next_m, 510);

        // Wrap 510 -> 511 -> 0, arriving out of order
        push_ch(4'd9, 16'h01FE, 16'h01FE);
        push_ch(4'd10, 16'h01FF, 16'h01FF);
        push_ch(4'd11, 16'h0100, 16'h0100);
        send(1, 511, 4'd10, 32'h0000_01FF, 1'b0, 1'b1);
        send(2, 0, 4'd11, 32'h0000_0100, 1'b0, 1'b1);
        send(0, 510, 4'd9, 32'h0000_01FE, 1'b0, 1'b1);
        tick(5);
        check("wrap_next", next_m, 1);
        check("stale_sticky", err_m, 1);

        // Reset with entries buffered behind a missing head
        send(0, 2, 4'd12, 32'h0000_0222, 1'b0, 1'b1);
        send(0, 3, 4'd13, 32'h0000_0333, 1'b0, 1'b1);
        send(0, 4, 4'd0, 32'h0000_0444, 1'b1, 1'b1);
        check("buf_count", cnt_m, 3);
        reset = 1'b1;
        #1;
        check("mid_rst_count", cnt_m, 0);
        check("mid_rst_next", next_m, 0);
        check("mid_rst_err", err_m, 0);
        tick(2);
        reset = 1'b0;
        tick(4);
        check("post_rst_count", cnt_m, 0);

        check("queue_empty_trunc", ch_q.size(), 0);
        check("queue_empty_sat", sat_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
